// File: rtl/d_digit_recoder_if.sv
// Bus bundle for d_digit_recoder: job load/status and the digit stream handshake.
interface d_digit_recoder_if #(
   parameter int unsigned W = 64
);
   localparam int unsigned IW = $clog2(W);

   logic          start;
   logic [W-1:0]  x_in;
   logic [W-1:0]  y_in;
   logic          busy;
   logic          d_valid;
   logic          d_ready;
   logic [1:0]    d_x;
   logic [1:0]    d_y;
   logic [IW-1:0] d_idx;
   logic          d_last;
   logic [IW+1:0] nz_cnt;

   modport master (
      output start, x_in, y_in, d_ready,
      input  busy, d_valid, d_x, d_y, d_idx, d_last, nz_cnt
   );

   modport slave (
      input  start, x_in, y_in, d_ready,
      output busy, d_valid, d_x, d_y, d_idx, d_last, nz_cnt
   );
endinterface

// File: rtl/d_digit_recoder.sv
// Booth-recodes a complex operand (x + jy) into a stream of signed digit pairs, one per transfer.
// XFIRE_DIGIT_MSB_FIRST_EN selects MSB-first digit order; LSB-first when undefined.
module d_digit_recoder #(
   parameter int unsigned W = 64
) (
   input  logic               clk,
   input  logic               arst_n,
   d_digit_recoder_if.slave   bus
);
   localparam int unsigned IW = $clog2(W);

`ifdef XFIRE_DIGIT_MSB_FIRST_EN
   localparam logic [IW-1:0] FIRST_IDX = IW'(W - 1);
   localparam logic [IW-1:0] LAST_IDX  = '0;
`else
   localparam logic [IW-1:0] FIRST_IDX = '0;
   localparam logic [IW-1:0] LAST_IDX  = IW'(W - 1);
`endif

   typedef enum logic {IDLE, RUN} state_t;

   state_t        state_q, state_d;
   logic [W-1:0]  x_q, x_d, y_q, y_d;
   logic [IW-1:0] idx_q, idx_d, idx_step;
   logic [1:0]    dx_q, dx_d, dy_q, dy_d;
   logic          last_q, last_d, busy_q, busy_d, valid_q, valid_d;
   logic [IW+1:0] nz_q, nz_d;
   logic          xfer;

   // digit_i = b[i-1] - b[i] with b[-1]=0, encoded 00=0, 01=+1, 11=-1
   function automatic logic [1:0] booth(input logic [W-1:0] op, input logic [IW-1:0] i);
      logic [W:0] ext;
      logic [1:0] pair;
      ext  = {op, 1'b0};
      pair = 2'(ext >> i);
      return {pair[1] & ~pair[0], pair[1] ^ pair[0]};
   endfunction

`ifdef XFIRE_DIGIT_MSB_FIRST_EN
   assign idx_step = idx_q - IW'(1);
`else
   assign idx_step = idx_q + IW'(1);
`endif

   assign xfer = valid_q & bus.d_ready;

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      idx_d   = idx_q;
      dx_d    = dx_q;
      dy_d    = dy_q;
      last_d  = last_q;
      busy_d  = busy_q;
      valid_d = valid_q;
      nz_d    = nz_q;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d = RUN;
               x_d     = bus.x_in;
               y_d     = bus.y_in;
               idx_d   = FIRST_IDX;
               dx_d    = booth(bus.x_in, FIRST_IDX);
               dy_d    = booth(bus.y_in, FIRST_IDX);
               last_d  = (FIRST_IDX == LAST_IDX);
               busy_d  = 1'b1;
               valid_d = 1'b1;
               nz_d    = '0;
            end
         end
         RUN: begin
            if (xfer) begin
               if ((dx_q != 2'b00) || (dy_q != 2'b00)) nz_d = nz_q + (IW+2)'(1);
               if (last_q) begin
                  state_d = IDLE;
                  dx_d    = 2'b00;
                  dy_d    = 2'b00;
                  last_d  = 1'b0;
                  busy_d  = 1'b0;
                  valid_d = 1'b0;
               end else begin
                  // the final index is never stepped past, so no wrap for any W
                  idx_d  = idx_step;
                  dx_d   = booth(x_q, idx_step);
                  dy_d   = booth(y_q, idx_step);
                  last_d = (idx_step == LAST_IDX);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q <= IDLE;
         x_q     <= '0;
         y_q     <= '0;
         idx_q   <= '0;
         dx_q    <= 2'b00;
         dy_q    <= 2'b00;
         last_q  <= 1'b0;
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
         nz_q    <= '0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         idx_q   <= idx_d;
         dx_q    <= dx_d;
         dy_q    <= dy_d;
         last_q  <= last_d;
         busy_q  <= busy_d;
         valid_q <= valid_d;
         nz_q    <= nz_d;
      end
   end

   assign bus.busy    = busy_q;
   assign bus.d_valid = valid_q;
   assign bus.d_x     = dx_q;
   assign bus.d_y     = dy_q;
   assign bus.d_idx   = idx_q;
   assign bus.d_last  = last_q;
   assign bus.nz_cnt  = nz_q;
endmodule

// File: tb/tb_d_digit_recoder.sv
// Scoreboarded bench for d_digit_recoder at W=4: expected digits queued at start, checked as emitted.
module tb_d_digit_recoder;
   localparam int unsigned W  = 4;
   localparam int unsigned IW = $clog2(W);

   typedef struct packed {
      logic [1:0]    dx;
      logic [1:0]    dy;
      logic [IW-1:0] idx;
      logic          last;
   } dig_t;

   logic clk = 1'b0;
   logic arst_n = 1'b0;
   int   n_cmp = 0;
   int   n_err = 0;
   int   n_xfer = 0;
   bit   idle_chk = 0;
   dig_t exp_q[$];

   always #5 clk = ~clk;

   d_digit_recoder_if #(.W(W)) bus ();

   d_digit_recoder #(.W(W)) dut (
      .clk    (clk),
      .arst_n (arst_n),
      .bus    (bus.slave)
   );

   function automatic int bit_at(input logic [W-1:0] v, input int i);
      return (i < 0) ? 0 : int'(v[i]);
   endfunction

   function automatic logic [1:0] enc(input int v);
      return (v == 0) ? 2'b00 : (v > 0) ? 2'b01 : 2'b11;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Digit stream model: digit_i = b[i-1] - b[i], emitted in the configured order.
   task automatic push_job(input logic [W-1:0] x, input logic [W-1:0] y, output int nz);
      dig_t e;
      nz = 0;
      for (int k = 0; k < int'(W); k++) begin
         int i;
`ifdef XFIRE_DIGIT_MSB_FIRST_EN
         i = int'(W) - 1 - k;
`else
         i = k;
`endif
         e.dx   = enc(bit_at(x, i - 1) - bit_at(x, i));
         e.dy   = enc(bit_at(y, i - 1) - bit_at(y, i));
         e.idx  = IW'(i);
         e.last = (k == int'(W) - 1);
         exp_q.push_back(e);
         if (e.dx != 2'b00 || e.dy != 2'b00) nz++;
      end
   endtask

   task automatic start_job(input logic [W-1:0] x, input logic [W-1:0] y, output int nz);
      bus.x_in  = x;
      bus.y_in  = y;
      bus.start = 1'b1;
      push_job(x, y, nz);
      @(posedge clk);
      #1 bus.start = 1'b0;
      chk("busy_valid_after_start", 32'({bus.busy, bus.d_valid}), 32'b11);
   endtask

   task automatic wait_idle(output int cyc);
      bit done;
      done = 0;
      cyc  = 0;
      for (int k = 0; k < 100 && !done; k++) begin
         @(negedge clk);
         if (bus.busy === 1'b0) done = 1;
         else cyc++;
      end
      n_cmp++;
      assert (done) else begin
         n_err++;
         $error("FAIL wait_idle observed=timeout expected=idle");
      end
      @(posedge clk);
      #1;
   endtask

   // Output monitor: compare the presented digit with the queue head; pop on transfer.
   always @(negedge clk) begin
      dig_t e, got;
      if (arst_n) begin
         if (idle_chk) begin
            idle_chk = 0;
            chk("idle_after_last", 32'({bus.busy, bus.d_valid}), 32'b00);
         end
         if (bus.d_valid === 1'b1) begin
            got = {bus.d_x, bus.d_y, bus.d_idx, bus.d_last};
            if (exp_q.size() == 0) begin
               chk("unexpected_digit", 32'(got), 32'hFFFF_FFFF);
            end else begin
               e = exp_q[0];
               chk("digit", 32'(got), 32'(e));
               if (bus.d_ready === 1'b1) begin
                  void'(exp_q.pop_front());
                  n_xfer++;
                  if (e.last) idle_chk = 1;
               end
            end
         end
      end
   end

   initial begin
      int nz, cyc, x0;
      logic [3:0] pat;
      logic [W-1:0] rx, ry;
      pat         = 4'b1001;
      bus.start   = 1'b0;
      bus.x_in    = '0;
      bus.y_in    = '0;
      bus.d_ready = 1'b1;
      #1;
      chk("reset_outputs", 32'({bus.busy, bus.d_valid, bus.d_last, bus.d_x, bus.d_y, bus.d_idx, bus.nz_cnt}), 32'd0);
      @(posedge clk);
      #1 arst_n = 1'b1;
      @(posedge clk);
      #1;

      // x=1, y=0 with continuous ready
      start_job(4'b0001, 4'b0000, nz);
      wait_idle(cyc);
      chk("run_cycles", 32'(cyc), 32'(W));
      chk("nz_cnt_0001", 32'(bus.nz_cnt), 32'd2);
      repeat (2) @(posedge clk);
      #1 chk("nz_cnt_hold", 32'(bus.nz_cnt), 32'd2);

      // x=0101 under 1,0,0,1 back-pressure
      x0 = n_xfer;
      start_job(4'b0101, 4'b0000, nz);
      for (int k = 0; k < 40; k++) begin
         bus.d_ready = pat[k % 4];
         @(posedge clk);
         #1;
         if (bus.busy !== 1'b1) break;
      end
      bus.d_ready = 1'b1;
      chk("stall_xfers", 32'(n_xfer - x0), 32'd4);
      chk("nz_cnt_0101", 32'(bus.nz_cnt), 32'd4);
      chk("stall_model_nz", 32'(bus.nz_cnt), 32'(nz));
      @(posedge clk);
      #1;

      // start pulses in RUN and on the final transfer are ignored
      start_job(4'b0011, 4'b0110, nz);
      @(posedge clk);
      #1 begin bus.start = 1'b1; bus.x_in = 4'b1111; bus.y_in = 4'b1010; end
      @(posedge clk);
      #1 bus.start = 1'b0;
      @(posedge clk);
      #1 bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      chk("idle_after_ignored_start", 32'(bus.busy), 32'd0);
      chk("nz_cnt_0011_0110", 32'(bus.nz_cnt), 32'(nz));
      start_job(4'b0110, 4'b1001, nz);
      wait_idle(cyc);
      chk("nz_cnt_0110_1001", 32'(bus.nz_cnt), 32'(nz));

      // reset after the second transfer aborts the job
      start_job(4'b0101, 4'b0011, nz);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1 arst_n = 1'b0;
      #1 exp_q.delete();
      chk("reset_abort_outputs", 32'({bus.busy, bus.d_valid, bus.d_last, bus.d_x, bus.d_y, bus.d_idx, bus.nz_cnt}), 32'd0);
      repeat (2) @(posedge clk);
      #1 arst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1 chk("no_resume_after_reset", 32'({bus.busy, bus.d_valid}), 32'd0);

      // x=1000, y=1111
      start_job(4'b1000, 4'b1111, nz);
      wait_idle(cyc);
      chk("nz_cnt_1000_1111", 32'(bus.nz_cnt), 32'd2);

      // random operands
      for (int r = 0; r < 4; r++) begin
         rx = W'($urandom);
         ry = W'($urandom);
         start_job(rx, ry, nz);
         wait_idle(cyc);
         chk("nz_cnt_random", 32'(bus.nz_cnt), 32'(nz));
      end
      chk("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
